mac_tx_framer: RTL and testbench
================================

MAC_TX_FRAMER -- requirements
Module: mac_tx_framer

Interface
REQ-001 Parameter PHY_W, default 4, meaning PHY data width in bits; legal values 4 (MII nibble) and 8 (GMII byte).
REQ-002 Parameter MAX_PAYLOAD, default 1500, meaning largest accepted payload length in bytes.
REQ-003 Parameter IFG_BYTES, default 12, meaning inter-frame gap in byte times.
REQ-004 Parameter SRC_MAC, default 48'h000A35000001, meaning source address inserted in every frame.
REQ-005 Port list (clock and reset first); one clock; reset is synchronous and active-high:
- clk  input  1  sole clock; all logic updates on posedge only.
- rst  input  1  synchronous, active-high reset.
- start  input  1  frame request; sampled in IDLE only.
- len_i  input  11  payload length in bytes.
- mac_i  input  48  destination MAC, MSB byte sent first.
- type_i  input  16  EtherType, MSB byte sent first.
- stream_i  input  8  payload byte.
- stb  input  1  stream_i valid.
- ack  output  1  payload byte consumed this cycle.
- busy  output  1  state is not IDLE.
- err  output  1  one-cycle pulse on rejected request or underrun.
- ETH_TX_EN  output  1  PHY transmit enable.
- ETH_TXD  output  PHY_W  PHY transmit data.

Function
REQ-006 States SHALL be IDLE, PRE, SFD, DST, SRC, TYPE, PAYLOAD, PAD, FCS and IFG, traversed in that order.
REQ-007 A byte time SHALL be 8/PHY_W cycles; with PHY_W=4, low nibble first, then high nibble.
REQ-008 In IDLE, start with 1<=len_i<=MAX_PAYLOAD SHALL latch len_i, mac_i and type_i and enter PRE on the next edge.
REQ-009 In IDLE, start with len_i=0 or len_i>MAX_PAYLOAD SHALL pulse err for one cycle and stay in IDLE.
REQ-010 start while busy SHALL be ignored.
REQ-011 PRE SHALL send 7 bytes of 0x55; SFD SHALL send 1 byte of 0xD5; DST, SRC and TYPE SHALL send 6, 6 and 2 bytes.
REQ-012 In PAYLOAD, at the first cycle of each byte time, ack SHALL equal stb; stream_i SHALL be captured when ack=1.
REQ-013 ack SHALL never assert outside PAYLOAD; exactly len bytes SHALL be acked per frame.
REQ-014 Underrun (stb=0 at a payload byte slot) SHALL:
- drop ETH_TX_EN on the next edge,
- pulse err for one cycle,
- enter IFG.
REQ-015 If len<46, PAD SHALL send 46-len bytes of 0x00; otherwise PAD is skipped.
REQ-016 ETH_TX_EN SHALL be 1 for exactly the cycles driving PRE through the last byte of PAD or FCS, and 0 otherwise.
REQ-017 ETH_TXD SHALL be 0 whenever ETH_TX_EN=0.
REQ-018 IFG SHALL hold ETH_TX_EN=0 for IFG_BYTES byte times, then return to IDLE.
REQ-019 Output latency: the first PRE data SHALL appear on ETH_TXD in the cycle after start is accepted.

Reset
REQ-020 rst SHALL force the following on the next edge, including mid-frame: state IDLE; ETH_TX_EN=0, ETH_TXD=0, ack=0, err=0, busy=0; all counters and latches cleared.
REQ-021 A frame interrupted by rst SHALL NOT resume, and SHALL NOT enforce an IFG.

Configuration
REQ-022 With macro MAC_TX_FCS_EN defined:
- FCS state sends 4 bytes of CRC-32 (poly 0x04C11DB7, reflected, init 0xFFFFFFFF, final XOR 0xFFFFFFFF), LSB first.
- CRC covers DST through PAD.
REQ-023 Without MAC_TX_FCS_EN, the FCS state and the CRC logic SHALL be absent, and PAD/PAYLOAD SHALL go directly to IFG.

Structure
REQ-024 Package mac_pkg SHALL hold:
- the state enum;
- constants PREAMBLE_BYTE=0x55, SFD_BYTE=0xD5, MIN_PAYLOAD=46, CRC_POLY, CRC_INIT.
REQ-025 Sub-module mac_crc32 (byte-wide, clear/enable inputs, 32-bit output) SHALL be instantiated only under MAC_TX_FCS_EN.

Verification
REQ-026 PHY_W=4, FCS on, len=46, stb held 1 -> ETH_TX_EN high 144 cycles; 46 acks; then 24 cycles idle gap; busy low afterwards.
REQ-027 len=1, stb=1 -> 1 ack; 45 bytes of 0x00 pad; frame still 72 bytes (144 cycles at PHY_W=4, 72 at PHY_W=8).
REQ-028 mac_crc32 fed ASCII "123456789" -> 0xCBF43926; in-frame FCS bytes match a software CRC of DST..PAD.
REQ-029 len=100, stb dropped at payload byte 10 -> exactly 10 acks; err one pulse; ETH_TX_EN low next edge; IFG, then IDLE.
REQ-030 len=0 and len=1501 -> err pulse; busy stays 0; ETH_TX_EN stays 0.
REQ-031 rst asserted during SRC -> next edge: ETH_TX_EN=0, busy=0; new start one cycle later is accepted normally.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared types and constants for the MAC transmit framer.
// MAC_TX_FCS_EN adds the FCS state to the state enum.
package mac_pkg;

   typedef enum logic [3:0] {
      StIdle    = 4'd0,
      StPre     = 4'd1,
      StSfd     = 4'd2,
      StDst     = 4'd3,
      StSrc     = 4'd4,
      StType    = 4'd5,
      StPayload = 4'd6,
      StPad     = 4'd7,
`ifdef MAC_TX_FCS_EN
      StFcs     = 4'd8,
`endif
      StIfg     = 4'd9
   } tx_state_e;

   localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0]  SFD_BYTE      = 8'hD5;
   localparam int unsigned MIN_PAYLOAD   = 46;
   localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
   localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;

   // Bit-reverse a 32-bit word (used to derive the reflected polynomial).
   function automatic logic [31:0] reflect32(input logic [31:0] v);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) begin
         r[i] = v[31-i];
      end
      return r;
   endfunction

   // Byte idx of a 48-bit address, counting from the most significant byte.
   function automatic logic [7:0] msb_byte48(input logic [47:0] v, input logic [2:0] idx);
      logic [7:0] b;
      case (idx)
         3'd0:    b = v[47:40];
         3'd1:    b = v[39:32];
         3'd2:    b = v[31:24];
         3'd3:    b = v[23:16];
         3'd4:    b = v[15:8];
         default: b = v[7:0];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/mac_crc32.sv
// Byte-wide Ethernet CRC-32 (reflected, init all-ones, output complemented).
// Only instantiated when MAC_TX_FCS_EN is defined.
module mac_crc32
   import mac_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        en,
   input  logic [7:0]  data,
   output logic [31:0] crc
);

   localparam logic [31:0] POLY_REFL = reflect32(CRC_POLY);

   logic [31:0] crc_q;
   logic [31:0] crc_d;

   // Fold one byte into the running remainder, LSB first.
   always_comb begin
      crc_d = crc_q;
      if (en) begin
         for (int i = 0; i < 8; i++) begin
            if (crc_d[0] ^ data[i]) begin
               crc_d = (crc_d >> 1) ^ POLY_REFL;
            end else begin
               crc_d = crc_d >> 1;
            end
         end
      end
   end

   // Remainder register; clear restarts a new frame.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         crc_q <= CRC_INIT;
      end else begin
         crc_q <= crc_d;
      end
   end

   assign crc = ~crc_q;

endmodule

// File: rtl/mac_tx_framer.sv
// Ethernet MAC transmit framer: preamble, SFD, addresses, EtherType, payload,
// zero pad to the minimum payload, optional FCS, then an inter-frame gap.
// Define MAC_TX_FCS_EN to append the CRC-32 FCS.
module mac_tx_framer
   import mac_pkg::*;
#(
   parameter int unsigned PHY_W       = 4,
   parameter int unsigned MAX_PAYLOAD = 1500,
   parameter int unsigned IFG_BYTES   = 12,
   parameter logic [47:0] SRC_MAC     = 48'h000A35000001
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [10:0]      len_i,
   input  logic [47:0]      mac_i,
   input  logic [15:0]      type_i,
   input  logic [7:0]       stream_i,
   input  logic             stb,
   output logic             ack,
   output logic             busy,
   output logic             err,
   output logic             ETH_TX_EN,
   output logic [PHY_W-1:0] ETH_TXD
);

   // Last phase index of a byte time: nibble 1 on MII, always 0 on GMII.
   localparam logic PH_LAST = (PHY_W == 8) ? 1'b0 : 1'b1;

`ifdef MAC_TX_FCS_EN
   localparam tx_state_e StAfterData = StFcs;
`else
   localparam tx_state_e StAfterData = StIfg;
`endif

   tx_state_e   state_q, state_d;
   logic        phase_q, phase_d;
   logic [15:0] cnt_q, cnt_d;
   logic [10:0] len_q;
   logic [47:0] mac_q;
   logic [15:0] type_q;
   logic [7:0]  byte_q;
   logic        err_q, err_d;
   logic        latch;
   logic        len_ok;
   logic        byte_end;
   logic        last_byte;
   logic        pad_needed;
   logic [15:0] pad_len;
   logic [15:0] limit;
   logic [7:0]  cur_byte;
   logic        tx_en;
   logic [PHY_W-1:0] txd_w;

   assign len_ok     = (len_i != 11'd0) && ({21'd0, len_i} <= MAX_PAYLOAD);
   assign pad_needed = (len_q < 11'(MIN_PAYLOAD));
   assign pad_len    = 16'(MIN_PAYLOAD) - {5'd0, len_q};
   assign byte_end   = (phase_q == PH_LAST);
   assign last_byte  = byte_end && (cnt_q == limit - 16'd1);

   // A payload byte is consumed at the first cycle of each payload byte time.
   assign ack  = (state_q == StPayload) && !phase_q && stb && !rst;
   assign busy = (state_q != StIdle);
   assign err  = err_q;

`ifdef MAC_TX_FCS_EN
   logic [31:0] crc_val;
   logic        crc_en;

   // CRC sees each DST..PAD byte once, on its first cycle; an underrun slot is skipped.
   assign crc_en = !phase_q && (state_q inside {StDst, StSrc, StType, StPayload, StPad}) &&
                   !((state_q == StPayload) && !stb);

   mac_crc32 u_crc32 (
      .clk  (clk),
      .rst  (rst),
      .clr  (state_q == StIdle),
      .en   (crc_en),
      .data (cur_byte),
      .crc  (crc_val)
   );
`endif

   // Number of byte times spent in the current state.
   always_comb begin
      limit = 16'd1;
      case (state_q)
         StPre:     limit = 16'd7;
         StSfd:     limit = 16'd1;
         StDst:     limit = 16'd6;
         StSrc:     limit = 16'd6;
         StType:    limit = 16'd2;
         StPayload: limit = {5'd0, len_q};
         StPad:     limit = pad_len;
`ifdef MAC_TX_FCS_EN
         StFcs:     limit = 16'd4;
`endif
         StIfg:     limit = 16'(IFG_BYTES);
         default:   limit = 16'd1;
      endcase
   end

   // Next-state, byte counter and nibble phase.
   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      cnt_d   = cnt_q;
      err_d   = 1'b0;
      latch   = 1'b0;
      if (state_q != StIdle) begin
         phase_d = byte_end ? 1'b0 : ~phase_q;
         if (byte_end) begin
            cnt_d = cnt_q + 16'd1;
         end
      end
      case (state_q)
         StIdle: begin
            if (start) begin
               if (len_ok) begin
                  state_d = StPre;
                  latch   = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         StPre:  if (last_byte) state_d = StSfd;
         StSfd:  if (last_byte) state_d = StDst;
         StDst:  if (last_byte) state_d = StSrc;
         StSrc:  if (last_byte) state_d = StType;
         StType: if (last_byte) state_d = StPayload;
         StPayload: begin
            if (!phase_q && !stb) begin
               // Underrun: abandon the frame but still honour the gap.
               state_d = StIfg;
               err_d   = 1'b1;
            end else if (last_byte) begin
               state_d = pad_needed ? StPad : StAfterData;
            end
         end
         StPad:  if (last_byte) state_d = StAfterData;
`ifdef MAC_TX_FCS_EN
         StFcs:  if (last_byte) state_d = StIfg;
`endif
         StIfg:  if (last_byte) state_d = StIdle;
         default: state_d = StIdle;
      endcase
      if (state_d != state_q) begin
         cnt_d   = 16'd0;
         phase_d = 1'b0;
      end
   end

   // Byte currently on the wire and transmit enable.
   always_comb begin
      cur_byte = 8'h00;
      tx_en    = 1'b1;
      case (state_q)
         StPre:     cur_byte = PREAMBLE_BYTE;
         StSfd:     cur_byte = SFD_BYTE;
         StDst:     cur_byte = msb_byte48(mac_q, cnt_q[2:0]);
         StSrc:     cur_byte = msb_byte48(SRC_MAC, cnt_q[2:0]);
         StType:    cur_byte = cnt_q[0] ? type_q[7:0] : type_q[15:8];
         // First cycle passes the input straight through; later cycles use the capture.
         StPayload: cur_byte = phase_q ? byte_q : (stb ? stream_i : 8'h00);
         StPad:     cur_byte = 8'h00;
`ifdef MAC_TX_FCS_EN
         StFcs: begin
            case (cnt_q[1:0])
               2'd0:    cur_byte = crc_val[7:0];
               2'd1:    cur_byte = crc_val[15:8];
               2'd2:    cur_byte = crc_val[23:16];
               default: cur_byte = crc_val[31:24];
            endcase
         end
`endif
         default:   tx_en = 1'b0;
      endcase
   end

   if (PHY_W == 8) begin : g_gmii
      assign txd_w = cur_byte;
   end else begin : g_mii
      assign txd_w = phase_q ? cur_byte[7:4] : cur_byte[3:0];
   end

   assign ETH_TX_EN = tx_en;
   assign ETH_TXD   = tx_en ? txd_w : '0;

   // State, counters, request latches and error pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         phase_q <= 1'b0;
         cnt_q   <= 16'd0;
         len_q   <= 11'd0;
         mac_q   <= 48'd0;
         type_q  <= 16'd0;
         byte_q  <= 8'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         if (latch) begin
            len_q  <= len_i;
            mac_q  <= mac_i;
            type_q <= type_i;
         end
         if (ack) begin
            byte_q <= stream_i;
         end
      end
   end

endmodule

// File: tb/tb_mac_tx_framer.sv
// Randomized self-checking bench for mac_tx_framer (PHY_W=4).
// Frames are predicted as byte lists; MAC_TX_FCS_EN adds FCS and a CRC unit check.
module tb_mac_tx_framer;

   localparam int unsigned IFG_BYTES = 12;
   localparam logic [47:0] SRC_MAC   = 48'h000A35000001;
   localparam int          MAX_CYC   = 4000;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [10:0] len_i;
   logic [47:0] mac_i;
   logic [15:0] type_i;
   logic [7:0]  stream_i;
   logic        stb;
   logic        ack;
   logic        busy;
   logic        err;
   logic        eth_tx_en;
   logic [3:0]  eth_txd;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   mac_tx_framer #(
      .PHY_W       (4),
      .MAX_PAYLOAD (1500),
      .IFG_BYTES   (IFG_BYTES),
      .SRC_MAC     (SRC_MAC)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .len_i     (len_i),
      .mac_i     (mac_i),
      .type_i    (type_i),
      .stream_i  (stream_i),
      .stb       (stb),
      .ack       (ack),
      .busy      (busy),
      .err       (err),
      .ETH_TX_EN (eth_tx_en),
      .ETH_TXD   (eth_txd)
   );

`ifdef MAC_TX_FCS_EN
   logic        c_clr;
   logic        c_en;
   logic [7:0]  c_data;
   logic [31:0] c_out;

   mac_crc32 u_crc (
      .clk  (clk),
      .rst  (rst),
      .clr  (c_clr),
      .en   (c_en),
      .data (c_data),
      .crc  (c_out)
   );
`endif

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Standard Ethernet CRC-32 over a byte list.
   function automatic logic [31:0] sw_crc(input logic [7:0] q[$]);
      logic [31:0] c;
      c = 32'hFFFFFFFF;
      foreach (q[i]) begin
         c = c ^ {24'h0, q[i]};
         for (int b = 0; b < 8; b++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
         end
      end
      return ~c;
   endfunction

   // Send one frame; drop_at >= 0 withdraws stb after that many payload bytes;
   // poke_at >= 0 raises a stray start at that cycle of the frame.
   task automatic run_frame(input int len, input int drop_at, input int poke_at);
      logic [7:0]  pay[$];
      logic [7:0]  expb[$];
      logic [7:0]  cov[$];
      logic [3:0]  nib[$];
      logic [47:0] dmac;
      logic [15:0] etype;
      logic [31:0] r;
      logic [31:0] fcs;
      int acks, en_cyc, first_en, en_fall, err_cnt, err_cyc, gap, nz_idle, n_pay;
      bit en_seen, done, normal;

      r = $urandom; dmac[47:32] = r[15:0];
      r = $urandom; dmac[31:0] = r;
      r = $urandom; etype = r[15:0];
      for (int i = 0; i < len; i++) begin
         r = $urandom; pay.push_back(r[7:0]);
      end
      normal = (drop_at < 0);
      n_pay  = normal ? len : drop_at;

      // Expected bytes on the wire.
      for (int i = 0; i < 7; i++) expb.push_back(8'h55);
      expb.push_back(8'hD5);
      for (int i = 0; i < 6; i++) cov.push_back(dmac[8*(5-i) +: 8]);
      for (int i = 0; i < 6; i++) cov.push_back(SRC_MAC[8*(5-i) +: 8]);
      cov.push_back(etype[15:8]);
      cov.push_back(etype[7:0]);
      for (int i = 0; i < n_pay; i++) cov.push_back(pay[i]);
      if (normal) begin
         for (int i = len; i < 46; i++) cov.push_back(8'h00);
      end
      foreach (cov[i]) expb.push_back(cov[i]);
`ifdef MAC_TX_FCS_EN
      if (normal) begin
         fcs = sw_crc(cov);
         for (int i = 0; i < 4; i++) expb.push_back(fcs[8*i +: 8]);
      end
`else
      fcs = 32'd0;
`endif

      acks = 0; en_cyc = 0; first_en = -1; en_fall = -1; err_cnt = 0; err_cyc = -2;
      gap = 0; nz_idle = 0; en_seen = 0; done = 0;
      start = 1'b1; len_i = 11'(len); mac_i = dmac; type_i = etype;
      for (int cyc = 0; cyc < MAX_CYC && !done; cyc++) begin
         stb      = normal || (acks < drop_at);
         stream_i = (acks < len) ? pay[acks] : 8'h00;
         if (cyc == poke_at) begin
            start = 1'b1; r = $urandom; len_i = r[10:0]; mac_i = 48'h0; type_i = 16'h0;
         end
         @(negedge clk);
         if (ack) acks++;
         if (eth_tx_en) begin
            if (!en_seen) first_en = cyc;
            en_seen = 1;
            en_cyc++;
            nib.push_back(eth_txd);
         end else begin
            if (eth_txd != 4'h0) nz_idle++;
            if (en_seen && en_fall < 0) en_fall = cyc;
            if (en_seen && busy) gap++;
         end
         if (err) begin
            err_cnt++;
            err_cyc = cyc;
         end
         if (en_seen && !busy) done = 1;
         @(posedge clk); #1;
         start = 1'b0;
      end
      stb = 1'b0;

      check("done", 64'(done), 64'd1);
      check("first_en", 64'(first_en), 64'd1);
      check("en_cycles", 64'(en_cyc), 64'(normal ? 2 * expb.size() : 2 * expb.size() + 1));
      check("acks", 64'(acks), 64'(n_pay));
      check("err_pulses", 64'(err_cnt), normal ? 64'd0 : 64'd1);
      if (!normal) check("err_at_drop", 64'(err_cyc), 64'(en_fall));
      check("ifg", 64'(gap), 64'(2 * IFG_BYTES));
      check("idle_txd", 64'(nz_idle), 64'd0);
      if (nib.size() >= 2 * expb.size()) begin
         for (int i = 0; i < expb.size(); i++) begin
            check("byte", 64'({nib[2*i+1], nib[2*i]}), 64'(expb[i]));
         end
      end
   endtask

   task automatic bad_request(input int len);
      int errs, bz, en;
      errs = 0; bz = 0; en = 0;
      start = 1'b1; len_i = 11'(len);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         errs += int'(err); bz += int'(busy); en += int'(eth_tx_en);
         @(posedge clk); #1;
         start = 1'b0;
      end
      check("bad_err", 64'(errs), 64'd1);
      check("bad_busy", 64'(bz), 64'd0);
      check("bad_en", 64'(en), 64'd0);
   endtask

   initial begin
      int en_cnt;
      rst = 1'b1; start = 1'b0; len_i = '0; mac_i = '0; type_i = '0; stream_i = '0; stb = 1'b0;
`ifdef MAC_TX_FCS_EN
      c_clr = 1'b0; c_en = 1'b0; c_data = 8'h00;
`endif
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_en", 64'(eth_tx_en), 64'd0);
      check("rst_txd", 64'(eth_txd), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_ack", 64'(ack), 64'd0);
      check("rst_err", 64'(err), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;

`ifdef MAC_TX_FCS_EN
      c_clr = 1'b1;
      @(posedge clk); #1;
      c_clr = 1'b0;
      for (int i = 0; i < 9; i++) begin
         c_en = 1'b1; c_data = 8'h31 + 8'(i);
         @(posedge clk); #1;
      end
      c_en = 1'b0;
      @(negedge clk);
      check("crc_check", 64'(c_out), 64'hCBF43926);
      @(posedge clk); #1;
`endif

      run_frame(46, -1, -1);
      run_frame(1, -1, -1);
      run_frame(100, 10, -1);
      bad_request(0);
      bad_request(1501);
      for (int k = 0; k < 5; k++) begin
         run_frame(int'($urandom_range(1, 120)), -1, (k == 2) ? 40 : -1);
      end
      run_frame(1500, -1, -1);

      // Reset in the middle of the source address, then restart immediately.
      start = 1'b1; len_i = 11'd60; mac_i = 48'h112233445566; type_i = 16'h0800;
      stb = 1'b1; stream_i = 8'hA5;
      en_cnt = 0;
      for (int k = 0; k < 200 && en_cnt < 32; k++) begin
         @(negedge clk);
         if (eth_tx_en) en_cnt++;
         @(posedge clk); #1;
         start = 1'b0;
      end
      check("pre_rst_en", 64'(en_cnt), 64'd32);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      stb = 1'b0;
      @(negedge clk);
      check("mid_rst_en", 64'(eth_tx_en), 64'd0);
      check("mid_rst_txd", 64'(eth_txd), 64'd0);
      check("mid_rst_busy", 64'(busy), 64'd0);
      check("mid_rst_err", 64'(err), 64'd0);
      @(posedge clk); #1;
      run_frame(60, -1, -1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
